// File: rtl/riscv_uc_multicycle.sv
// riscv_uc_multicycle
//
// Multicycle control unit for the RISC-V datapath. The unit steps each
// instruction through FETCH, DECODE, EXEC, MEM and WB. Instruction fetch and
// data access share one memory port, and both wait on mem_ready.
//
// Optional feature: define RISCV_UC_MEM_TIMEOUT_EN to bound every memory wait
// to MEM_TIMEOUT cycles. A wait that runs past this limit traps with
// trap_cause=1. Without the macro, waits are unbounded and trap_cause is
// always 0.
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   opcode[6:0]    in   IR[6:0], stable from DECODE until the next IR load
//   alu_zero       in   ALU zero flag, used by branches in EXEC
//   mem_ready      in   memory completes the current access this cycle
//   pc_reset       out  clear PC
//   pc_load        out  load PC
//   pc_src         out  0 = PC+4, 1 = old_pc+imm
//   ir_load        out  load IR and old_pc
//   mem_addr_sel   out  0 = PC, 1 = ALU result
//   mem_re/mem_we  out  memory read / write strobes
//   reg_file_write out  register file write enable
//   alu_op[1:0]    out  00 add, 01 sub, 10 decode by funct
//   select_mux_1   out  ALU B: 0 = rs2, 1 = immediate
//   select_mux_2   out  writeback: 0 = ALU, 1 = memory data
//   instr_done     out  pulse on the last cycle of each instruction
//   trap           out  sticky error flag
//   trap_cause     out  0 = illegal opcode, 1 = memory timeout
module riscv_uc_multicycle #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_reset,
  output logic       pc_load,
  output logic       pc_src,
  output logic       ir_load,
  output logic       mem_addr_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_file_write,
  output logic [1:0] alu_op,
  output logic       select_mux_1,
  output logic       select_mux_2,
  output logic       instr_done,
  output logic       trap,
  output logic       trap_cause
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  state_t state, state_next;
  logic   is_r, is_load, is_store, is_branch;
  logic   timeout_hit;

  assign is_r      = (opcode == OP_R);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RST;
    else          state <= state_next;
  end

`ifdef RISCV_UC_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // The counter freezes in TRAP. A timeout leaves it at MEM_TIMEOUT. An
  // illegal-opcode trap leaves it at 0, because the counter clears on entry
  // to DECODE. trap_cause therefore needs no separate flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (state == ST_TRAP)
      wait_cnt <= wait_cnt;
    else if (state_next != state && state_next != ST_TRAP)
      wait_cnt <= '0;
    else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the wait cycle that brings the count up to MEM_TIMEOUT.
  // A ready in that cycle completes the access instead.
  assign timeout_hit = (state == ST_FETCH || state == ST_MEM) && !mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign trap_cause  = (state == ST_TRAP) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
`else
  assign timeout_hit = 1'b0;
  assign trap_cause  = 1'b0;
`endif

  assign trap = (state == ST_TRAP);

  always_comb begin
    state_next     = state;
    pc_reset       = 1'b0;
    pc_load        = 1'b0;
    pc_src         = 1'b0;
    ir_load        = 1'b0;
    mem_addr_sel   = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    reg_file_write = 1'b0;
    alu_op         = 2'b00;
    select_mux_1   = 1'b0;
    select_mux_2   = 1'b0;
    instr_done     = 1'b0;
    case (state)
      ST_RST: begin
        pc_reset   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_load    = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (is_r || is_load || is_store || is_branch) state_next = ST_EXEC;
        else                                         state_next = ST_TRAP;
      end
      ST_EXEC: begin
        if (is_r) begin
          alu_op     = 2'b10;
          state_next = ST_WB;
        end else if (is_load || is_store) begin
          select_mux_1 = 1'b1;
          state_next   = ST_MEM;
        end else if (is_branch) begin
          alu_op     = 2'b01;
          pc_src     = 1'b1;
          pc_load    = alu_zero;
          instr_done = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_TRAP;
        end
      end
      ST_MEM: begin
        // The ALU keeps computing the address for the whole access.
        mem_addr_sel = 1'b1;
        select_mux_1 = 1'b1;
        if (is_load) mem_re = 1'b1;
        else         mem_we = 1'b1;
        if (mem_ready) begin
          if (is_load) begin
            state_next = ST_WB;
          end else begin
            instr_done = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_file_write = 1'b1;
        instr_done     = 1'b1;
        select_mux_2   = is_load;
        state_next     = ST_FETCH;
      end
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_riscv_uc_multicycle.sv
// Testbench for riscv_uc_multicycle.
//
// The stimulus process drives the inputs for each cycle just after the rising
// edge. It then queues the expected output vector for that cycle. A monitor
// process takes one entry from the queue at each falling edge and compares it
// with the DUT outputs.
module tb_riscv_uc_multicycle;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_reset, pc_load, pc_src, ir_load, mem_addr_sel, mem_re, mem_we;
  logic       reg_file_write, select_mux_1, select_mux_2, instr_done, trap, trap_cause;
  logic [1:0] alu_op;

  riscv_uc_multicycle #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_reset(pc_reset), .pc_load(pc_load),
    .pc_src(pc_src), .ir_load(ir_load), .mem_addr_sel(mem_addr_sel),
    .mem_re(mem_re), .mem_we(mem_we), .reg_file_write(reg_file_write),
    .alu_op(alu_op), .select_mux_1(select_mux_1), .select_mux_2(select_mux_2),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Output vector bit positions.
  localparam logic [14:0] B_PCR  = 15'h4000;  // pc_reset
  localparam logic [14:0] B_PCL  = 15'h2000;  // pc_load
  localparam logic [14:0] B_PCS  = 15'h1000;  // pc_src
  localparam logic [14:0] B_IRL  = 15'h0800;  // ir_load
  localparam logic [14:0] B_MAS  = 15'h0400;  // mem_addr_sel
  localparam logic [14:0] B_MRE  = 15'h0200;  // mem_re
  localparam logic [14:0] B_MWE  = 15'h0100;  // mem_we
  localparam logic [14:0] B_RFW  = 15'h0080;  // reg_file_write
  localparam logic [14:0] B_SUB  = 15'h0020;  // alu_op = 01
  localparam logic [14:0] B_FUN  = 15'h0040;  // alu_op = 10
  localparam logic [14:0] B_M1   = 15'h0010;  // select_mux_1
  localparam logic [14:0] B_M2   = 15'h0008;  // select_mux_2
  localparam logic [14:0] B_DONE = 15'h0004;  // instr_done
  localparam logic [14:0] B_TRP  = 15'h0002;  // trap
  localparam logic [14:0] B_CAU  = 15'h0001;  // trap_cause

  // Expected output patterns, derived by hand from the state tables.
  localparam logic [14:0] E_RST       = B_PCR;
  localparam logic [14:0] E_FETCH_W   = B_MRE;
  localparam logic [14:0] E_FETCH_R   = B_MRE | B_IRL | B_PCL;
  localparam logic [14:0] E_DECODE    = 15'h0000;
  localparam logic [14:0] E_EXEC_R    = B_FUN;
  localparam logic [14:0] E_EXEC_LS   = B_M1;
  localparam logic [14:0] E_EXEC_BT   = B_SUB | B_PCL | B_PCS | B_DONE;
  localparam logic [14:0] E_EXEC_BN   = B_SUB | B_PCS | B_DONE;
  localparam logic [14:0] E_MEM_LD    = B_MAS | B_MRE | B_M1;
  localparam logic [14:0] E_MEM_ST    = B_MAS | B_MWE | B_M1;
  localparam logic [14:0] E_MEM_ST_D  = B_MAS | B_MWE | B_M1 | B_DONE;
  localparam logic [14:0] E_WB_R      = B_RFW | B_DONE;
  localparam logic [14:0] E_WB_LD     = B_RFW | B_DONE | B_M2;
  localparam logic [14:0] E_TRAP0     = B_TRP;
  localparam logic [14:0] E_TRAP1     = B_TRP | B_CAU;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b0010111;

  typedef struct {
    logic [14:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [14:0] actual();
    return {pc_reset, pc_load, pc_src, ir_load, mem_addr_sel, mem_re, mem_we,
            reg_file_write, alu_op, select_mux_1, select_mux_2, instr_done,
            trap, trap_cause};
  endfunction

  task automatic compare(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: outputs=%015b expected=%015b", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a new output vector every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        compare(e.name, e.exp);
      end
    end
  end

  // Drives the inputs for one cycle and queues the expected outputs.
  task automatic step(input logic rst_n_v, input logic rdy, input logic zero,
                      input logic [6:0] op, input logic [14:0] exp,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n   = rst_n_v;
    mem_ready = rdy;
    alu_zero  = zero;
    opcode    = op;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, outputs=%015b", actual());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released. The first cycle after release is RST.
    step(0, 1, 0, OP_R, E_RST, "reset_hold0");
    step(0, 1, 0, OP_R, E_RST, "reset_hold1");
    step(1, 1, 0, OP_R, E_RST, "rst_state");
    // R-type with zero-wait memory.
    step(1, 1, 0, OP_R, E_FETCH_R, "r_fetch");
    step(1, 1, 0, OP_R, E_DECODE,  "r_decode");
    step(1, 1, 0, OP_R, E_EXEC_R,  "r_exec");
    step(1, 1, 0, OP_R, E_WB_R,    "r_wb");
    // Load: one fetch wait, then two waits on the data access.
    step(1, 0, 0, OP_LD, E_FETCH_W, "ld_fetch_wait");
    step(1, 1, 0, OP_LD, E_FETCH_R, "ld_fetch");
    step(1, 1, 0, OP_LD, E_DECODE,  "ld_decode");
    step(1, 1, 0, OP_LD, E_EXEC_LS, "ld_exec");
    step(1, 0, 0, OP_LD, E_MEM_LD,  "ld_mem_w1");
    step(1, 0, 0, OP_LD, E_MEM_LD,  "ld_mem_w2");
    step(1, 1, 0, OP_LD, E_MEM_LD,  "ld_mem_rdy");
    step(1, 1, 0, OP_LD, E_WB_LD,   "ld_wb");
    // Store with zero-wait memory.
    step(1, 1, 0, OP_ST, E_FETCH_R,  "st_fetch");
    step(1, 1, 0, OP_ST, E_DECODE,   "st_decode");
    step(1, 1, 0, OP_ST, E_EXEC_LS,  "st_exec");
    step(1, 1, 0, OP_ST, E_MEM_ST_D, "st_mem");
    // Branch taken, then branch not taken.
    step(1, 1, 1, OP_BR, E_FETCH_R, "bt_fetch");
    step(1, 1, 1, OP_BR, E_DECODE,  "bt_decode");
    step(1, 1, 1, OP_BR, E_EXEC_BT, "bt_exec");
    step(1, 1, 0, OP_BR, E_FETCH_R, "bn_fetch");
    step(1, 1, 0, OP_BR, E_DECODE,  "bn_decode");
    step(1, 1, 0, OP_BR, E_EXEC_BN, "bn_exec");
    // Store interrupted by reset while it waits in MEM.
    step(1, 1, 0, OP_ST, E_FETCH_R, "sr_fetch");
    step(1, 1, 0, OP_ST, E_DECODE,  "sr_decode");
    step(1, 1, 0, OP_ST, E_EXEC_LS, "sr_exec");
    step(1, 0, 0, OP_ST, E_MEM_ST,  "sr_mem_wait");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    compare("sr_async_reset", E_RST);
    step(0, 0, 0, OP_ST, E_RST, "sr_reset_hold");
    step(1, 1, 0, OP_ILL, E_RST, "ill_rst_state");
    // Illegal opcode: the unit traps after DECODE and stays in TRAP.
    step(1, 1, 0, OP_ILL, E_FETCH_R, "ill_fetch");
    step(1, 1, 0, OP_ILL, E_DECODE,  "ill_decode");
    for (int i = 0; i < 21; i++)
      step(1, i[0], i[1], (i[2] ? OP_R : OP_ILL), E_TRAP0, $sformatf("ill_trap%0d", i));
    // mem_ready held low in FETCH.
    step(0, 0, 0, OP_R, E_RST, "to_reset");
    step(1, 0, 0, OP_R, E_RST, "to_rst_state");
`ifdef RISCV_UC_MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++)
      step(1, 0, 0, OP_R, E_FETCH_W, $sformatf("to_wait%0d", i));
    step(1, 0, 0, OP_R, E_TRAP1, "to_trap");
    step(1, 1, 0, OP_R, E_TRAP1, "to_trap_held");
`else
    for (int i = 0; i < 40; i++)
      step(1, 0, 0, OP_R, E_FETCH_W, $sformatf("to_wait%0d", i));
`endif
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_uc_multicycle.md
# riscv_uc_multicycle

Multicycle control unit for the RISC-V datapath. It replaces the single-cycle decode with a state machine that sequences fetch, decode, execute, memory access and writeback over several cycles. It shares one memory port between instruction fetch and data access, and waits on a memory ready handshake. It sits beside the datapath and drives the PC, IR, register file, ALU, mux selects and memory strobes.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles spent waiting for `mem_ready` in one access. Used only with the timeout feature.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: `IR[6:0]`. Stable from DECODE until the next IR load.
- `alu_zero` in 1: ALU zero flag. Sampled in EXEC for branches.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_reset` out 1: clears the PC.
- `pc_load` out 1: loads the PC.
- `pc_src` out 1: PC source. 0 = PC+4, 1 = branch target, computed by the datapath as old_pc+imm.
- `ir_load` out 1: loads IR and old_pc.
- `mem_addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `reg_file_write` out 1: register file write enable.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = decode by funct.
- `select_mux_1` out 1: ALU B source. 0 = rs2, 1 = immediate.
- `select_mux_2` out 1: writeback source. 0 = ALU, 1 = memory data.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `trap` out 1: sticky error flag.
- `trap_cause` out 1: 0 = illegal opcode, 1 = memory timeout.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, TRAP. The state register is the only storage, apart from the timeout counter.
- Outputs are combinational from the state. The listed exceptions also depend on `mem_ready` or `alu_zero`. Every output not listed for a state is 0.
- RST:
  - Outputs: `pc_reset`=1.
  - Next state: FETCH.
- FETCH:
  - Outputs: `mem_re`=1, `mem_addr_sel`=0.
  - On `mem_ready`=1: `ir_load`=1, `pc_load`=1, `pc_src`=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - The register file is read. Next state depends on `opcode`:
  - 0110011, 0000011, 0100011 or 1100011 -> EXEC.
  - Any other value -> TRAP with cause 0.
- EXEC, R-type: `alu_op`=10, `select_mux_1`=0, then WB.
- EXEC, load or store: `alu_op`=00, `select_mux_1`=1, then MEM.
- EXEC, branch:
  - Outputs: `alu_op`=01, `select_mux_1`=0, `instr_done`=1.
  - `pc_load`=`alu_zero` and `pc_src`=1, so the PC is reloaded only when the branch is taken.
  - Next state: FETCH.
- MEM: `mem_addr_sel`=1, `alu_op`=00, `select_mux_1`=1. This holds the address stable for the whole access.
  - Load: `mem_re`=1. On `mem_ready`, go to WB.
  - Store: `mem_we`=1. On `mem_ready`, `instr_done`=1 and go to FETCH.
  - Without `mem_ready`, stay in MEM.
- WB:
  - Outputs: `reg_file_write`=1, `instr_done`=1.
  - `select_mux_2`=1 for a load, 0 for R-type.
  - Next state: FETCH.
- TRAP:
  - Outputs: `trap`=1, `trap_cause` held. All strobes and loads are 0.
  - Leaves TRAP only on reset.
- `reset_n` low asserts immediately and forces RST, whatever the current state or any access in progress. Memory strobes drop in the same cycle.

## Timing
- Reset values: state=RST; `pc_reset`=1; every other output 0; `trap_cause`=0.
- Cycle counts per instruction, with zero-wait memory (`mem_ready` high on the first cycle):
  - Branch: 3 cycles.
  - R-type: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds exactly one cycle.
- `mem_re` and `mem_we` are never high together. Both are held constant while waiting.
- `ir_load` and `pc_load` are high in FETCH only in the single cycle where `mem_ready`=1.

## Configuration
- `RISCV_UC_MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to FETCH or MEM and increments each cycle with `mem_ready`=0.
  - When it reaches `MEM_TIMEOUT`, the next state is TRAP with `trap_cause`=1.
  - If `mem_ready` arrives in the same cycle as the count is reached, `mem_ready` wins.
- Not defined: the counter is not built, waits are unbounded and `trap_cause` is only ever 0.

## Test plan
- Reset and R-type: release `reset_n`, `mem_ready` tied to 1, `opcode`=0110011.
  - Required: one cycle of `pc_reset`, then FETCH/DECODE/EXEC/WB.
  - `reg_file_write`=1 only in cycle 5 after reset, with `select_mux_2`=0 and `instr_done`=1.
- Load with 2 wait cycles on the data access, `opcode`=0000011.
  - Required: `mem_re`=1 and `mem_addr_sel`=1 held for 3 cycles in MEM.
  - Then WB with `select_mux_2`=1.
- Branch, `opcode`=1100011, `alu_zero`=1 then `alu_zero`=0.
  - Required: `pc_load`=1 with `pc_src`=1 in EXEC for the first.
  - `pc_load`=0 in EXEC for the second.
- Illegal opcode 0010111.
  - Required: TRAP after DECODE, `trap`=1, `trap_cause`=0.
  - All strobes stay 0 for 20 further cycles.
- `reset_n` asserted mid-MEM of a store.
  - Required: `mem_we` drops in the same cycle and all outputs take their reset values.
- With `RISCV_UC_MEM_TIMEOUT_EN` and `MEM_TIMEOUT`=15, `mem_ready` held at 0 in FETCH.
  - Required: TRAP entered after 15 wait cycles, `trap_cause`=1.
  - Without the macro, the unit remains in FETCH indefinitely.
